// File: rtl/imdct_if.sv
// imdct_if: sequencer <-> control/datapath bundle for imdct_seq.
//   Control side : start, npts, es_in (run request); fft_done, fft_es (FFT reply)
//   Status       : busy, done, fft_start
//   ALU side     : mode, es
//   RAM/ROM side : ram_re, ram_raddr, rom_addr, ram_raddr_a0, ram_we, ram_waddr
// master = sequencer, slave = the surrounding control/datapath.
interface imdct_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W:0]   npts;
  logic [4:0]        es_in;
  logic              fft_done;
  logic [4:0]        fft_es;
  logic              busy;
  logic              done;
  logic              fft_start;
  logic              mode;
  logic [4:0]        es;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;
  logic [ADDR_W-1:0] rom_addr;
  logic              ram_raddr_a0;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;

  modport master (
    input  start, npts, es_in, fft_done, fft_es,
    output busy, done, fft_start, mode, es,
           ram_re, ram_raddr, rom_addr, ram_raddr_a0, ram_we, ram_waddr
  );

  modport slave (
    output start, npts, es_in, fft_done, fft_es,
    input  busy, done, fft_start, mode, es,
           ram_re, ram_raddr, rom_addr, ram_raddr_a0, ram_we, ram_waddr
  );
endinterface

// File: rtl/imdct_seq.sv
// imdct_seq: sequencer for the IMDCT twiddle ALU.
// On start it runs a pre-twiddle pass (mode=0) over npts complex points,
// pulses fft_start, waits for fft_done, then runs a post-twiddle pass
// (mode=1) over the same points and pulses done. Each pass issues one
// RAM/ROM read per cycle and replays the read index as the write index
// once the ALU result is ready (1 cycle RAM latency + ALU_LAT).
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - imdct_if master modport (see imdct_if.sv)
module imdct_seq #(
  parameter int ADDR_W  = 8,
  parameter int ALU_LAT = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  imdct_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_PRE_DRAIN, S_FFT_WAIT, S_POST, S_POST_DRAIN
  } state_t;

  localparam logic [ADDR_W:0] K_ONE = 1;

  state_t state, state_nxt;

  // k and npts_q are one bit wider than an index so npts = 2^ADDR_W
  // ends cleanly at k = 2^ADDR_W-1 without wrapping into a reissue of 0.
  logic [ADDR_W:0]   k;
  logic [ADDR_W:0]   npts_q;
  logic [4:0]        fft_es_q;

  logic              issue;
  logic              accept_start;
  logic              accept_fft;
  logic              last_issue;
  logic              drain_done;

  logic              ram_re_q;
  logic [ADDR_W-1:0] raddr_q;
  logic              a0_q;
  logic              mode_q;
  logic [4:0]        es_q;
  logic              fft_start_q;
  logic              done_q;

  // Write-back pipeline: stage 0 lines up with RAM data, stage ALU_LAT
  // lines up with the ALU result.
  logic [ALU_LAT:0]  vld;
  logic [ADDR_W-1:0] widx [ALU_LAT+1];

  assign last_issue = (k == npts_q - K_ONE);

  // Drain ends on the cycle the final write is on the RAM port and
  // nothing else is behind it.
  assign drain_done = !ram_re_q && vld[ALU_LAT] && (vld[ALU_LAT-1:0] == '0);

  // NOTE: every always_comb output gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    issue        = 1'b0;
    accept_start = 1'b0;
    accept_fft   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start && (bus.npts != '0)) begin
          accept_start = 1'b1;
          state_nxt    = S_PRE;
        end
      end
      S_PRE: begin
        issue = 1'b1;
        if (last_issue) state_nxt = S_PRE_DRAIN;
      end
      S_PRE_DRAIN: begin
        if (drain_done) state_nxt = S_FFT_WAIT;
      end
      S_FFT_WAIT: begin
        if (bus.fft_done) begin
          accept_fft = 1'b1;
          state_nxt  = S_POST;
        end
      end
      S_POST: begin
        issue = 1'b1;
        if (last_issue) state_nxt = S_POST_DRAIN;
      end
      S_POST_DRAIN: begin
        if (drain_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only,
  // so every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k           <= '0;
      npts_q      <= '0;
      fft_es_q    <= '0;
      ram_re_q    <= 1'b0;
      raddr_q     <= '0;
      a0_q        <= 1'b0;
      mode_q      <= 1'b0;
      es_q        <= '0;
      fft_start_q <= 1'b0;
      done_q      <= 1'b0;
      vld         <= '0;
      // NOTE: the index stages are reset along with the valid bits so
      // ram_waddr reads 0 out of reset; the array is only ALU_LAT+1 deep.
      for (int i = 0; i <= ALU_LAT; i++) widx[i] <= '0;
    end else begin
      if (accept_start) begin
        npts_q <= bus.npts;
        es_q   <= bus.es_in;
      end
      if (accept_fft) fft_es_q <= bus.fft_es;

      if (accept_start || accept_fft) k <= '0;
      else if (issue)                 k <= k + K_ONE;

      ram_re_q <= issue;
      raddr_q  <= issue ? k[ADDR_W-1:0] : '0;
      a0_q     <= raddr_q[0];

      // mode/es switch together with the first post issue, when the
      // ALU pipeline is empty, and return to 0 on re-entry to IDLE.
      if (state == S_POST) begin
        mode_q <= 1'b1;
        es_q   <= fft_es_q;
      end
      if (state == S_POST_DRAIN && drain_done) begin
        mode_q <= 1'b0;
        es_q   <= '0;
      end

      fft_start_q <= (state == S_PRE_DRAIN)  && drain_done;
      done_q      <= (state == S_POST_DRAIN) && drain_done;

      vld     <= {vld[ALU_LAT-1:0], ram_re_q};
      widx[0] <= raddr_q;
      for (int i = 1; i <= ALU_LAT; i++) widx[i] <= widx[i-1];
    end
  end

  // busy stays high through the done pulse, dropping the cycle after.
  assign bus.busy         = (state != S_IDLE) || done_q;
  assign bus.done         = done_q;
  assign bus.fft_start    = fft_start_q;
  assign bus.mode         = mode_q;
  assign bus.es           = es_q;
  assign bus.ram_re       = ram_re_q;
  assign bus.ram_raddr    = raddr_q;
  assign bus.rom_addr     = raddr_q;
  assign bus.ram_raddr_a0 = a0_q;
  assign bus.ram_we       = vld[ALU_LAT];
  assign bus.ram_waddr    = widx[ALU_LAT];

endmodule

// File: tb/tb_imdct_seq.sv
// tb_imdct_seq: self-checking bench for imdct_seq (ADDR_W=8, ALU_LAT=4).
// Each run is checked cycle by cycle against a timeline derived from the
// start/fft_done edges, plus per-run totals from a vector table.
module tb_imdct_seq;
  localparam int AW = 8;
  localparam int L  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imdct_if #(.ADDR_W(AW)) bus ();

  imdct_seq #(.ADDR_W(AW), .ALU_LAT(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int npts; int es_in; int fft_es; int t; bit inj;
    int exp_fs; int exp_done; int exp_wr;
  } vec_t;

  typedef struct {
    int re; int raddr; int a0; int we; int waddr;
    int fs; int dn; int mode; int busy;
  } exp_t;

  // Expected outputs for cycle c of a run whose start was accepted at
  // edge 0 and whose fft_done was accepted at edge t.
  function automatic exp_t model(input int c, input int n, input int t);
    exp_t e;
    e = '{default: 0};
    if (c >= 1 && c <= n)             begin e.re = 1; e.raddr = c - 1; end
    if (c >= t + 1 && c <= t + n)     begin e.re = 1; e.raddr = c - t - 1; end
    if (c >= 2 && c <= n + 1)         e.a0 = (c - 2) % 2;
    if (c >= t + 2 && c <= t + n + 1) e.a0 = (c - t - 2) % 2;
    if (c >= 2 + L && c <= n + 1 + L)         begin e.we = 1; e.waddr = c - 2 - L; end
    if (c >= t + 2 + L && c <= t + n + 1 + L) begin e.we = 1; e.waddr = c - t - 2 - L; end
    e.fs   = (c == n + 2 + L) ? 1 : 0;
    e.dn   = (c == t + n + 2 + L) ? 1 : 0;
    e.mode = (c >= t + 1 && c <= t + n + 1 + L) ? 1 : 0;
    e.busy = (c <= t + n + 2 + L) ? 1 : 0;
    return e;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},         32'(bus.busy), 0);
    check({tag, " done"},         32'(bus.done), 0);
    check({tag, " fft_start"},    32'(bus.fft_start), 0);
    check({tag, " mode"},         32'(bus.mode), 0);
    check({tag, " es"},           32'(bus.es), 0);
    check({tag, " ram_re"},       32'(bus.ram_re), 0);
    check({tag, " ram_raddr"},    32'(bus.ram_raddr), 0);
    check({tag, " rom_addr"},     32'(bus.rom_addr), 0);
    check({tag, " ram_raddr_a0"}, 32'(bus.ram_raddr_a0), 0);
    check({tag, " ram_we"},       32'(bus.ram_we), 0);
    check({tag, " ram_waddr"},    32'(bus.ram_waddr), 0);
  endtask

  // One full pre/FFT/post run. With inj set, a start (npts=7) and an
  // fft_done arrive during PRE, and another fft_done on the edge that
  // enters FFT_WAIT; all must be ignored.
  task automatic run_vec(input vec_t v, input string tag);
    int fs_cyc, dn_cyc, wr_cnt, re_cnt, end_c;
    exp_t e;
    fs_cyc = -1; dn_cyc = -1; wr_cnt = 0; re_cnt = 0;
    end_c  = v.t + v.npts + L + 4;
    @(negedge clk);
    bus.start = 1'b1;
    bus.npts  = (AW+1)'(v.npts);
    bus.es_in = 5'(v.es_in);
    for (int c = 0; c <= end_c; c++) begin
      @(negedge clk);
      e = model(c, v.npts, v.t);
      check($sformatf("%s c%0d ram_re", tag, c),       32'(bus.ram_re), 32'(e.re));
      check($sformatf("%s c%0d ram_raddr", tag, c),    32'(bus.ram_raddr), 32'(e.raddr));
      check($sformatf("%s c%0d rom_addr", tag, c),     32'(bus.rom_addr), 32'(e.raddr));
      check($sformatf("%s c%0d raddr_a0", tag, c),     32'(bus.ram_raddr_a0), 32'(e.a0));
      check($sformatf("%s c%0d ram_we", tag, c),       32'(bus.ram_we), 32'(e.we));
      check($sformatf("%s c%0d ram_waddr", tag, c),    32'(bus.ram_waddr), 32'(e.waddr));
      check($sformatf("%s c%0d fft_start", tag, c),    32'(bus.fft_start), 32'(e.fs));
      check($sformatf("%s c%0d done", tag, c),         32'(bus.done), 32'(e.dn));
      check($sformatf("%s c%0d mode", tag, c),         32'(bus.mode), 32'(e.mode));
      if (c >= 1) check($sformatf("%s c%0d busy", tag, c), 32'(bus.busy), 32'(e.busy));
      if (c >= 1 && c <= v.t)
        check($sformatf("%s c%0d es pre", tag, c), 32'(bus.es), 32'(v.es_in));
      else if (c > v.t && c <= v.t + v.npts + 1 + L)
        check($sformatf("%s c%0d es post", tag, c), 32'(bus.es), 32'(v.fft_es));
      if (bus.fft_start === 1'b1 && fs_cyc < 0) fs_cyc = c;
      if (bus.done === 1'b1 && dn_cyc < 0)      dn_cyc = c;
      if (bus.ram_we === 1'b1) wr_cnt++;
      if (bus.ram_re === 1'b1) re_cnt++;
      // Drive inputs for the next edge.
      bus.start    = v.inj && (c == 1);
      bus.npts     = (AW+1)'((v.inj && c == 1) ? 7 : v.npts);
      bus.es_in    = 5'($urandom_range(0, 31));
      bus.fft_done = (c == v.t - 1) || (v.inj && (c == 1 || c == v.npts + 1 + L));
      bus.fft_es   = (c == v.t - 1) ? 5'(v.fft_es) : 5'($urandom_range(0, 31));
    end
    bus.fft_done = 1'b0;
    check({tag, " fft_start cycle"}, 32'(fs_cyc), 32'(v.exp_fs));
    check({tag, " done cycle"},      32'(dn_cyc), 32'(v.exp_done));
    check({tag, " write count"},     32'(wr_cnt), 32'(v.exp_wr));
    check({tag, " issue count"},     32'(re_cnt), 32'(2 * v.npts));
  endtask

  initial begin
    vec_t vecs [5];
    vec_t rv;

    // {npts, es_in, fft_es, t, inj, fft_start cycle, done cycle, writes}
    vecs[0] = '{4,   2,  3,  20,  1'b0, 10,  30,  8};
    vecs[1] = '{4,   2,  3,  20,  1'b1, 10,  30,  8};
    vecs[2] = '{1,   0,  31, 12,  1'b0, 7,   19,  2};
    vecs[3] = '{3,   31, 0,  15,  1'b1, 9,   24,  6};
    vecs[4] = '{256, 5,  7,  300, 1'b0, 262, 562, 512};

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      bus.start    = 1'($urandom_range(0, 1));
      bus.npts     = (AW+1)'($urandom_range(0, 256));
      bus.es_in    = 5'($urandom_range(0, 31));
      bus.fft_done = 1'($urandom_range(0, 1));
      bus.fft_es   = 5'($urandom_range(0, 31));
      @(negedge clk);
    end
    check_all_zero("reset");
    bus.start = 1'b0; bus.fft_done = 1'b0; bus.npts = '0;
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // start with npts == 0 is ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.npts = '0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("npts0 c%0d busy", i),   32'(bus.busy), 0);
      check($sformatf("npts0 c%0d ram_re", i), 32'(bus.ram_re), 0);
      @(negedge clk);
    end

    // Randomized runs against the timeline model.
    for (int r = 0; r < 6; r++) begin
      rv.npts     = $urandom_range(1, 20);
      rv.es_in    = $urandom_range(0, 31);
      rv.fft_es   = $urandom_range(0, 31);
      rv.t        = rv.npts + 3 + L + $urandom_range(0, 6);
      rv.inj      = 1'($urandom_range(0, 1));
      rv.exp_fs   = rv.npts + 2 + L;
      rv.exp_done = rv.t + rv.npts + 2 + L;
      rv.exp_wr   = 2 * rv.npts;
      run_vec(rv, $sformatf("rnd%0d", r));
    end

    // Reset during the post pass at issue 2 of 4.
    @(negedge clk);
    bus.start = 1'b1; bus.npts = (AW+1)'(4); bus.es_in = 5'(2);
    for (int c = 0; c <= 23; c++) begin
      @(negedge clk);
      bus.start    = 1'b0;
      bus.fft_done = (c == 19);
      bus.fft_es   = 5'(3);
    end
    check("abort ram_raddr before reset", 32'(bus.ram_raddr), 2);
    check("abort ram_re before reset",    32'(bus.ram_re), 1);
    #1 rst_n = 1'b0;
    #1 check_all_zero("abort async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("abort c%0d ram_we", i), 32'(bus.ram_we), 0);
      check($sformatf("abort c%0d busy", i),   32'(bus.busy), 0);
    end

    // Clean sequence after the abort.
    run_vec(vecs[0], "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
